// File: rtl/inv_round_key.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round Nr,
// then walks back one round key per accepted handshake down to round 0.
module inv_round_key #(
  parameter int KEY_S = 128,
  parameter int Nr    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_S-1:0] key,
  input  logic             key_load,
  output logic             busy,
  output logic [KEY_S-1:0] round_key,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_round,
  output logic             done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;
  localparam logic [3:0] NR_W     = 4'(Nr);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_S-1:0] key_q, key_d;
  logic             done_q, done_d;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)) with rcon folded into the leading byte
  function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [7:0] rc);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {SBOX[rot[31:24]] ^ rc, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ g_fn(k[31:0], rc);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    d = k[31:0] ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ g_fn(d, rc);
    return {a, b, c, d};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_load) begin
          key_d   = key;
          cnt_d   = 4'd0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (cnt_q == NR_W) begin
          state_d = S_OUTPUT;
        end else begin
          key_d = fwd_step(key_q, rcon(4'(cnt_q + 4'd1)));
          cnt_d = 4'(cnt_q + 4'd1);
        end
      end
      S_OUTPUT: begin
        if (rk_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = inv_step(key_q, rcon(cnt_q));
            cnt_d = 4'(cnt_q - 4'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rk_valid  = (state_q == S_OUTPUT);
  assign round_key = key_q;
  assign rk_round  = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_round_key.sv
// Randomized self-checking bench for inv_round_key against a full AES-128
// key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_inv_round_key;

  logic         clk;
  logic         reset;
  logic [127:0] key;
  logic         key_load;
  logic         busy;
  logic [127:0] round_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic         done;

  int checks;
  int errors;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  inv_round_key #(.KEY_S(128), .Nr(10)) dut (
    .clk(clk), .reset(reset), .key(key), .key_load(key_load), .busy(busy),
    .round_key(round_key), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_round(rk_round), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_schedule(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]] ^ rc, sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({busy, rk_valid, done, rk_round, round_key} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b vld=%b done=%b rnd=%0d rk=%h expected all zero",
               busy, rk_valid, done, rk_round, round_key);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_fips();
    compute_schedule(FIPS_KEY);
    rk_ready = 1'b1;
    key = FIPS_KEY;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fips_latency10 vld=%b busy=%b expected vld=0 busy=1", rk_valid, busy);
    end
    step();
    checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd10 || round_key !== FIPS_R10) begin
      errors++;
      $display("FAIL fips_round10 vld=%b rnd=%0d rk=%h expected 1/10/%h", rk_valid, rk_round, round_key, FIPS_R10);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
        errors++;
        $display("FAIL fips_seq vld=%b rnd=%0d rk=%h expected round %0d %h", rk_valid, rk_round, round_key, r, exp_rk[r]);
      end
      if (r == 1) begin
        checks++;
        if (round_key !== FIPS_R1) begin
          errors++;
          $display("FAIL fips_round1 rk=%h expected %h", round_key, FIPS_R1);
        end
      end
      if (r == 0) begin
        checks++;
        if (round_key !== FIPS_KEY) begin
          errors++;
          $display("FAIL fips_round0 rk=%h expected %h", round_key, FIPS_KEY);
        end
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_done done=%b vld=%b busy=%b expected 1/0/0", done, rk_valid, busy);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_pulse done=%b expected 0", done);
    end
    rk_ready = 1'b0;
  endtask

  // Random ready (and optionally stray key_load pulses with a decoy key) while draining
  task automatic test_random_drain(input logic [127:0] k, input bit poke_load);
    int  r;
    int  guard;
    bit  fin;
    bit  hs;
    compute_schedule(k);
    key = k;
    key_load = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      key_load = poke_load ? 1'($urandom_range(0, 1)) : 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
      rk_ready = 1'($urandom_range(0, 1));
      step();
    end
    key_load = 1'b0;
    rk_ready = 1'($urandom_range(0, 1));
    step();
    r = 10;
    guard = 0;
    fin = 1'b0;
    while (!fin && guard < 300) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
        errors++;
        $display("FAIL rand_seq vld=%b rnd=%0d rk=%h expected round %0d %h", rk_valid, rk_round, round_key, r, exp_rk[r]);
      end
      rk_ready = 1'($urandom_range(0, 1));
      hs = rk_ready;
      key_load = (poke_load && r > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      if (hs) begin
        if (r == 0) fin = 1'b1;
        else r--;
      end
      guard++;
    end
    key_load = 1'b0;
    rk_ready = 1'b0;
    checks++;
    if (!fin || done !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_end fin=%b done=%b vld=%b expected 1/1/0", fin, done, rk_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    key = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    rk_ready = 1'b1;
    guard = 0;
    while (!(rk_valid === 1'b1 && rk_round === 4'd5) && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL reset_mid_reach rnd=%0d vld=%b expected round 5 valid", rk_round, rk_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, rk_valid, done, rk_round, round_key} !== '0) begin
      errors++;
      $display("FAIL reset_async busy=%b vld=%b done=%b rnd=%0d rk=%h expected all zero",
               busy, rk_valid, done, rk_round, round_key);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rk_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort vld=%b done=%b busy=%b expected 0/0/0", rk_valid, done, busy);
      end
    end
    compute_schedule(128'h0);
    key = 128'h0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload busy=%b expected 1", busy);
    end
    for (int i = 0; i < 11; i++) step();
    checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd10 || round_key !== ZERO_R10) begin
      errors++;
      $display("FAIL zero_round10 vld=%b rnd=%0d rk=%h expected 1/10/%h", rk_valid, rk_round, round_key, ZERO_R10);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
        errors++;
        $display("FAIL zero_seq rnd=%0d rk=%h expected round %0d %h", rk_round, round_key, r, exp_rk[r]);
      end
      step();
    end
    rk_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    compute_schedule(ka);
    rk_ready = 1'b1;
    key = ka;
    key_load = 1'b1;
    step();
    key = kb;
    for (int i = 0; i < 11; i++) step();
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
        errors++;
        $display("FAIL b2b_first rnd=%0d rk=%h expected round %0d %h", rk_round, round_key, r, exp_rk[r]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap done=%b busy=%b expected 1/0", done, busy);
    end
    step();
    key_load = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b expected 1/0", busy, done);
    end
    compute_schedule(kb);
    for (int i = 0; i < 11; i++) step();
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
        errors++;
        $display("FAIL b2b_second rnd=%0d rk=%h expected round %0d %h", rk_round, round_key, r, exp_rk[r]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done done=%b expected 1", done);
    end
    rk_ready = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    key = '0;
    key_load = 1'b0;
    rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_random_drain(FIPS_KEY, 1'b0);
    test_random_drain({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    test_random_drain({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_round_key.md
INV_ROUND_KEY -- requirements
Module: inv_round_key

Interface
REQ-001 Parameter: KEY_S, default 128, key width in bits; AES-128 only, other values unsupported.
REQ-002 Parameter: Nr, default 10, number of AES rounds.
REQ-003 Port: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port: reset, input, 1, reset is asynchronous and active-high.
REQ-005 Port: key, input, KEY_S, cipher key; bit 0 = MSB, word 0 = bits 0..31, byte 0 = bits 0..7.
REQ-006 Port: key_load, input, 1, request to load key; accepted only in IDLE.
REQ-007 Port: busy, output, 1, high in every state except IDLE.
REQ-008 Port: round_key, output, KEY_S, decryption-order round key currently presented.
REQ-009 Port: rk_valid, output, 1, round_key/rk_round valid.
REQ-010 Port: rk_ready, input, 1, consumer accepts round_key when high together with rk_valid.
REQ-011 Port: rk_round, output, 4, round index of round_key (Nr down to 0).
REQ-012 Port: done, output, 1, one-cycle pulse after round 0 key accepted.

Function
REQ-013 States SHALL be IDLE, EXPAND, OUTPUT.
REQ-014 IDLE: key_load high -> register key, round counter = 0, go EXPAND; key_load SHALL be ignored in EXPAND/OUTPUT.
REQ-015 EXPAND: each cycle apply forward step with rcon(counter+1), increment counter; after 10th step go OUTPUT with counter = Nr.
REQ-016 Forward step: g = SubWord(RotWord(w3)) with rcon XORed into byte 0; w0'=w0^g, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-017 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-018 OUTPUT: rk_valid high, round_key = key register, rk_round = counter.
REQ-019 rk_valid SHALL first assert 11 cycles after the key_load accept edge, with rk_round = 10.
REQ-020 Handshake (rk_valid & rk_ready) with rk_round = r > 0: apply inverse step with rcon(r), counter = r-1; next key valid the following cycle (one key per cycle at full throughput).
REQ-021 Inverse step from {a',b',c',d'}: d=d'^c', c=c'^b', b=b'^a', a=a'^g(d) with g per REQ-016 using rcon(r).
REQ-022 rk_ready low in OUTPUT: round_key, rk_round, rk_valid SHALL hold stable.
REQ-023 Handshake at rk_round = 0: go IDLE, rk_valid low next cycle, done high for exactly that one cycle.
REQ-024 rk_ready while not rk_valid SHALL have no effect.
REQ-025 SubWord SHALL use the standard AES forward S-box, combinational, single cycle.

Reset
REQ-026 reset high SHALL asynchronously force IDLE, counter = 0, key register = 0, busy = 0, rk_valid = 0, done = 0, rk_round = 0, round_key = 0.
REQ-027 reset mid-EXPAND or mid-OUTPUT SHALL abort; no further rk_valid or done until a new key_load.
REQ-028 First key_load SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-029 Load 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> cycle +11: rk_round=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6; then keys 9..0 on consecutive cycles, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = input key, done pulse after.
REQ-030 Same key, rk_ready toggled randomly -> identical 11-key sequence, each key held stable while rk_ready low, no skipped or repeated rounds.
REQ-031 key_load pulsed during EXPAND and OUTPUT with a different key -> ignored; output sequence matches first key.
REQ-032 reset asserted while rk_round=5 -> all outputs 0 immediately (asynchronous); subsequent load of all-zero key yields round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 Back-to-back: key_load held high continuously -> second key accepted in the IDLE cycle following done; busy low for exactly that one cycle.
